// File: rtl/rr_arbiter_lock.sv
// rr_arbiter_lock: N-requester round-robin arbiter with grant locking.
// The owner keeps the grant until it pulses done or drops its request. The
// release hands the grant straight to the next requester in round-robin order,
// with no idle cycle in between.
// Optional feature macro: ARB_TIMEOUT_EN. When it is defined, a hold counter
// force-releases an owner that has held the grant for MAX_HOLD cycles.
//
// Request/grant protocol: a requester holds req[i] high until it sees grant[i].
// It then keeps req[i] high for as long as it needs the resource and pulses
// done[i] on its last cycle. Dropping req[i] without done is an abort. All
// inputs are sampled only on the rising edge, and every output is a register.
module rr_arbiter_lock #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         done,
  output logic [N-1:0]         grant,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 timeout,
  output logic                 state_dbg
);

  localparam int IDW = $clog2(N);
  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   ptr_q, ptr_d;

  logic             own_req;
  logic             own_done;
  logic             force_rel;
  logic             take;
  logic [IDW-1:0]   sel;
  logic [IDW:0]     win_all;
  logic [IDW:0]     win_masked;

`ifdef ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  logic [HW-1:0]    hold_q, hold_d;
  logic             timeout_q, timeout_d;
`endif

  // First set bit of r scanning upward from p with wrap-around; {found, index}.
  // The loop runs from the far end back toward p, so the nearest hit is written last and wins.
  function automatic logic [IDW:0] pick(input logic [N-1:0] r, input logic [IDW-1:0] p);
    logic [IDW:0] res;
    int           idx;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(p) + k;
      if (idx >= N) idx = idx - N;
      if (r[idx]) res = {1'b1, idx[IDW-1:0]};
    end
    return res;
  endfunction

  // Successor index modulo N (N need not be a power of two).
  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] w);
    if (int'(w) == N - 1) return '0;
    return w + 1'b1;
  endfunction

  // Next-state and next-grant logic. The scan that skips the owner uses grant_q as its mask.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    id_d       = id_q;
    ptr_d      = ptr_q;
    take       = 1'b0;
    sel        = '0;
    force_rel  = 1'b0;
    own_req    = req[id_q];
    own_done   = done[id_q];
    win_all    = pick(req, ptr_q);
    win_masked = pick(req & ~grant_q, ptr_q);
`ifdef ARB_TIMEOUT_EN
    hold_d     = hold_q;
    timeout_d  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (win_all[IDW]) begin
          take = 1'b1;
          sel  = win_all[IDW-1:0];
        end
      end
      BUSY: begin
`ifdef ARB_TIMEOUT_EN
        force_rel = (hold_q == HOLD_LAST) & own_req & ~own_done;
`endif
        if (own_done | ~own_req | force_rel) begin
`ifdef ARB_TIMEOUT_EN
          timeout_d = force_rel;
`endif
          if (win_masked[IDW]) begin
            take = 1'b1;
            sel  = win_masked[IDW-1:0];
          end else if (own_req) begin
            // Nobody else is asking, so the still-requesting owner is granted again.
            take = 1'b1;
            sel  = id_q;
          end else begin
            // Pointer keeps owner+1 from the original grant.
            state_d = IDLE;
            grant_d = '0;
            id_d    = '0;
          end
        end else begin
`ifdef ARB_TIMEOUT_EN
          hold_d = hold_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    if (take) begin
      state_d = BUSY;
      grant_d = ONE_HOT0 << sel;
      id_d    = sel;
      ptr_d   = next_id(sel);
`ifdef ARB_TIMEOUT_EN
      hold_d  = '0;
`endif
    end
`ifdef ARB_TIMEOUT_EN
    if (state_d == IDLE) hold_d = '0;
`endif
  end

  // State, grant and pointer registers; reset is asynchronous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Hold counter and the one-cycle forced-release pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign grant       = grant_q;
  assign grant_id    = id_q;
  assign grant_valid = (state_q == BUSY);
  assign state_dbg   = (state_q == BUSY);

endmodule

// File: tb/tb_rr_arbiter_lock.sv
// Testbench for rr_arbiter_lock (N=4, MAX_HOLD=4). Build with or without
// ARB_TIMEOUT_EN; the reference model follows the same macro.
module tb_rr_arbiter_lock;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;
  localparam int IDW      = $clog2(N);
  localparam int VW       = N + 1 + IDW + 1;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_r;
  logic [N-1:0]   done_r;
  logic [N-1:0]   grant;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  logic           timeout;
  logic           state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: the current owner (-1 when idle), the rotation start index, and the hold count.
  int   m_owner;
  int   m_ptr;
  int   m_hold;
  logic m_to;

  logic [N-1:0] exp_q[$];

  rr_arbiter_lock #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req_r),
    .done        (done_r),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .timeout     (timeout),
    .state_dbg   (state_dbg)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int scan(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (p + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
    m_to    = 1'b0;
  endfunction

  function automatic void model_step(input logic [N-1:0] r, input logic [N-1:0] d);
    int w;
    logic [N-1:0] masked;
    bit forced;
    m_to = 1'b0;
    if (m_owner < 0) begin
      w = scan(r, m_ptr);
      if (w >= 0) begin
        m_owner = w; m_ptr = (w + 1) % N; m_hold = 0;
      end
    end else begin
      forced = TO_EN && (m_hold >= MAX_HOLD - 1) && r[m_owner] && !d[m_owner];
      if (d[m_owner] || !r[m_owner] || forced) begin
        masked = r;
        masked[m_owner] = 1'b0;
        w = scan(masked, m_ptr);
        if (w < 0 && r[m_owner]) w = m_owner;
        m_to = forced;
        if (w >= 0) begin
          m_owner = w; m_ptr = (w + 1) % N; m_hold = 0;
        end else begin
          m_owner = -1; m_hold = 0;
        end
      end else begin
        m_hold++;
      end
    end
  endfunction

  function automatic logic [N-1:0] exp_grant();
    logic [N-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  function automatic logic [VW-1:0] model_vec();
    logic [IDW-1:0] id;
    id = (m_owner >= 0) ? m_owner[IDW-1:0] : '0;
    return {exp_grant(), (m_owner >= 0), id, m_to};
  endfunction

  // ---------------- driver tasks ----------------
  // Drive inputs, take one rising edge, advance the model, then settle 1 time unit past the edge.
  task automatic tick(input logic [N-1:0] r, input logic [N-1:0] d);
    req_r  = r;
    done_r = d;
    @(posedge clk);
    model_step(r, d);
    #1;
  endtask

  task automatic do_reset();
    req_r  = '0;
    done_r = '0;
    rst    = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; req_r = '1; done_r = '0;
    #1;
    n_checks++;
    if ({grant, grant_valid, grant_id, timeout} !== '0) begin
      n_fail++;
      $display("FAIL reset_async got=%b want=0", {grant, grant_valid, grant_id, timeout});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({grant, grant_valid, grant_id, timeout} !== '0) begin
      n_fail++;
      $display("FAIL reset_held got=%b want=0", {grant, grant_valid, grant_id, timeout});
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_alternate();
    logic [VW-1:0] obs;
    logic [N-1:0]  want;
    do_reset();
    exp_q = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
    for (int i = 0; i < 4; i++) begin
      tick(4'b0101, (i == 0) ? 4'b0000 : exp_grant());
      want = exp_q.pop_front();
      obs  = {grant, grant_valid, grant_id, timeout};
      n_checks++;
      if (grant !== want) begin
        n_fail++;
        $display("FAIL alternate_seq[%0d] grant=%b want=%b", i, grant, want);
      end
      n_checks++;
      if (obs !== model_vec()) begin
        n_fail++;
        $display("FAIL alternate_model[%0d] got=%b want=%b", i, obs, model_vec());
      end
    end
  endtask

  task automatic test_rotation();
    logic [VW-1:0] obs;
    logic [N-1:0]  want;
    do_reset();
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 5; i++) begin
      tick(4'b1111, (i == 0) ? 4'b0000 : exp_grant());
      want = exp_q.pop_front();
      obs  = {grant, grant_valid, grant_id, timeout};
      n_checks++;
      if (grant !== want) begin
        n_fail++;
        $display("FAIL rotation_seq[%0d] grant=%b want=%b", i, grant, want);
      end
      n_checks++;
      if (obs !== model_vec()) begin
        n_fail++;
        $display("FAIL rotation_model[%0d] got=%b want=%b", i, obs, model_vec());
      end
    end
  endtask

  task automatic test_hold_lock();
    logic [VW-1:0] obs;
    do_reset();
    tick(4'b0010, 4'b0000);
    n_checks++;
    if (grant !== 4'b0010) begin
      n_fail++;
      $display("FAIL hold_first grant=%b want=0010", grant);
    end
    for (int i = 0; i < 10; i++) begin
      tick(4'b1010, 4'b0000);
      obs = {grant, grant_valid, grant_id, timeout};
      n_checks++;
      if (obs !== model_vec()) begin
        n_fail++;
        $display("FAIL hold_cycle[%0d] got=%b want=%b", i, obs, model_vec());
      end
    end
    tick(4'b1010, 4'b0010);
    obs = {grant, grant_valid, grant_id, timeout};
    n_checks++;
    if (obs !== model_vec()) begin
      n_fail++;
      $display("FAIL hold_release got=%b want=%b", obs, model_vec());
    end
`ifndef ARB_TIMEOUT_EN
    n_checks++;
    if (grant !== 4'b1000) begin
      n_fail++;
      $display("FAIL hold_handover grant=%b want=1000", grant);
    end
`endif
  endtask

  task automatic test_abort();
    do_reset();
    tick(4'b0100, 4'b0000);
    tick(4'b0000, 4'b0000);
    n_checks++;
    if ({grant, grant_valid, grant_id} !== '0) begin
      n_fail++;
      $display("FAIL abort_idle got=%b want=0", {grant, grant_valid, grant_id});
    end
    tick(4'b0000, 4'b1111);
    n_checks++;
    if ({grant, grant_valid} !== '0) begin
      n_fail++;
      $display("FAIL done_in_idle got=%b want=0", {grant, grant_valid});
    end
    tick(4'b0001, 4'b0000);
    n_checks++;
    if ({grant, grant_valid, grant_id} !== {4'b0001, 1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL abort_regrant got=%b want=0001_1_00", {grant, grant_valid, grant_id});
    end
    tick(4'b0001, 4'b1000);
    n_checks++;
    if ({grant, grant_valid, grant_id} !== {4'b0001, 1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL foreign_done got=%b want=0001_1_00", {grant, grant_valid, grant_id});
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick(4'b0100, 4'b0000);
    tick(4'b0100, 4'b0000);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({grant, grant_valid, grant_id} !== '0) begin
      n_fail++;
      $display("FAIL async_reset got=%b want=0", {grant, grant_valid, grant_id});
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    tick(4'b1000, 4'b0000);
    n_checks++;
    if ({grant, grant_valid, grant_id} !== {4'b1000, 1'b1, 2'd3}) begin
      n_fail++;
      $display("FAIL post_reset_grant got=%b want=1000_1_11", {grant, grant_valid, grant_id});
    end
  endtask

  task automatic test_timeout();
    do_reset();
    tick(4'b0011, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      tick(4'b0011, 4'b0000);
      n_checks++;
      if ({grant, timeout} !== {4'b0001, 1'b0}) begin
        n_fail++;
        $display("FAIL timeout_hold[%0d] got=%b want=0001_0", i, {grant, timeout});
      end
    end
    tick(4'b0011, 4'b0000);
`ifdef ARB_TIMEOUT_EN
    n_checks++;
    if ({grant, timeout} !== {4'b0010, 1'b1}) begin
      n_fail++;
      $display("FAIL timeout_fire got=%b want=0010_1", {grant, timeout});
    end
    tick(4'b0011, 4'b0000);
    n_checks++;
    if ({grant, timeout} !== {4'b0010, 1'b0}) begin
      n_fail++;
      $display("FAIL timeout_pulse got=%b want=0010_0", {grant, timeout});
    end
`else
    for (int i = 0; i < 6; i++) begin
      tick(4'b0011, 4'b0000);
      n_checks++;
      if ({grant, timeout} !== {4'b0001, 1'b0}) begin
        n_fail++;
        $display("FAIL no_timeout[%0d] got=%b want=0001_0", i, {grant, timeout});
      end
    end
`endif
  endtask

  task automatic test_random();
    logic [VW-1:0] obs;
    logic [N-1:0]  r, d;
    do_reset();
    r = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) r = N'($urandom_range(0, (1 << N) - 1));
      d = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, (1 << N) - 1)) : '0;
      tick(r, d);
      obs = {grant, grant_valid, grant_id, timeout};
      n_checks++;
      if (obs !== model_vec()) begin
        n_fail++;
        $display("FAIL random[%0d] req=%b done=%b got=%b want=%b", i, r, d, obs, model_vec());
      end
    end
  endtask

  // Test sequence and final report.
  initial begin
    rst = 1'b1; req_r = '0; done_r = '0;
    model_reset();
    test_reset();
    test_alternate();
    test_rotation();
    test_hold_lock();
    test_abort();
    test_async_reset();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
